// File: rtl/mpu_bus_arbiter.sv
// Two-port arbiter for the NT35510 MPU write path: command sequences and pixel bursts
// share one write engine. Pixel bursts are preceded by a RAMWR/RAMWRC header word.
module mpu_bus_arbiter #(
   parameter int unsigned           DATA_WIDTH = 16,
   parameter int unsigned           LEN_WIDTH  = 10,
   parameter logic [DATA_WIDTH-1:0] CMD_RAMWR  = 16'h2C00,
   parameter logic [DATA_WIDTH-1:0] CMD_RAMWRC = 16'h3C00,
   parameter bit                    FAIR       = 1'b1
) (
   input  logic                  i_arst,
   input  logic                  i_sysclk,
   input  logic                  i_cmd_valid,
   input  logic                  i_cmd_dcx,
   input  logic [DATA_WIDTH-1:0] i_cmd_data,
   input  logic                  i_cmd_last,
   output logic                  o_cmd_ready,
   input  logic                  i_pix_req,
   input  logic                  i_pix_cont,
   input  logic [LEN_WIDTH-1:0]  i_pix_len,
   output logic                  o_pix_gnt,
   input  logic                  i_pix_valid,
   input  logic [DATA_WIDTH-1:0] i_pix_data,
   output logic                  o_pix_ready,
   output logic                  o_bus_valid,
   output logic                  o_bus_dcx,
   output logic [DATA_WIDTH-1:0] o_bus_data,
   input  logic                  i_bus_ready,
   output logic [1:0]            o_grant,
   output logic                  o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_HDR, S_PIX} state_t;
   typedef enum logic {OWN_CMD, OWN_PIX} owner_t;

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   state_t                 state_q, state_d;
   owner_t                 last_owner_q, last_owner_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic                   cont_q, cont_d;
   logic                   pix_gnt_q, pix_gnt_d;
   logic                   cmd_wins;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge i_sysclk or posedge i_arst) begin
      if (i_arst) begin
         state_q      <= S_IDLE;
         last_owner_q <= OWN_PIX;
         len_q        <= '0;
         cont_q       <= 1'b0;
         pix_gnt_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         len_q        <= len_d;
         cont_q       <= cont_d;
         pix_gnt_q    <= pix_gnt_d;
      end
   end

   // Command takes the slot when alone, when fairness is off, or when pixel went last.
   assign cmd_wins = i_cmd_valid && (!i_pix_req || (FAIR == 1'b0) || (last_owner_q == OWN_PIX));

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d      = state_q;
      last_owner_d = last_owner_q;
      len_d        = len_q;
      cont_d       = cont_q;
      pix_gnt_d    = 1'b0;
      o_bus_valid  = 1'b0;
      o_bus_dcx    = 1'b0;
      o_bus_data   = '0;
      o_cmd_ready  = 1'b0;
      o_pix_ready  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_wins) begin
               state_d = S_CMD;
            end else if (i_pix_req) begin
               state_d   = S_HDR;
               pix_gnt_d = 1'b1;
               len_d     = i_pix_len;
               cont_d    = i_pix_cont;
            end
         end
         S_CMD: begin
            o_bus_valid = i_cmd_valid;
            o_bus_dcx   = i_cmd_dcx;
            o_bus_data  = i_cmd_data;
            o_cmd_ready = i_bus_ready;
            if (i_cmd_valid && i_bus_ready && i_cmd_last) begin
               state_d      = S_IDLE;
               last_owner_d = OWN_CMD;
            end
         end
         S_HDR: begin
            o_bus_valid = 1'b1;
            o_bus_data  = cont_q ? CMD_RAMWRC : CMD_RAMWR;
            if (i_bus_ready) begin
               if (len_q == '0) begin
                  state_d      = S_IDLE;
                  last_owner_d = OWN_PIX;
               end else begin
                  state_d = S_PIX;
               end
            end
         end
         S_PIX: begin
            o_bus_valid = i_pix_valid;
            o_bus_dcx   = 1'b1;
            o_bus_data  = i_pix_data;
            o_pix_ready = i_bus_ready;
            if (i_pix_valid && i_bus_ready) begin
               len_d = len_q - LEN_ONE;
               if (len_q == LEN_ONE) begin
                  state_d      = S_IDLE;
                  last_owner_d = OWN_PIX;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_pix_gnt = pix_gnt_q;
   assign o_busy    = (state_q != S_IDLE);
   assign o_grant   = (state_q == S_CMD)                         ? 2'b01 :
                      ((state_q == S_HDR) || (state_q == S_PIX)) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_mpu_bus_arbiter.sv
// Self-checking bench for mpu_bus_arbiter: a table of per-cycle vectors plus hand
// sequences for arbitration fairness, mid-burst reset and the maximum burst length.
module tb_mpu_bus_arbiter;

   logic        arst, clk;
   logic        cmd_valid, cmd_dcx, cmd_last, pix_req, pix_cont, pix_valid, bus_ready;
   logic [15:0] cmd_data, pix_data;
   logic [9:0]  pix_len;

   logic        cmd_ready, pix_gnt, pix_ready, bus_valid, bus_dcx, busy;
   logic [15:0] bus_data;
   logic [1:0]  grant;

   logic        u_cmd_ready, u_pix_gnt, u_pix_ready, u_bus_valid, u_bus_dcx, u_busy;
   logic [15:0] u_bus_data;
   logic [1:0]  u_grant;

   int n_checks = 0;
   int n_fail   = 0;

   mpu_bus_arbiter #(.FAIR(1'b1)) dut (
      .i_arst(arst), .i_sysclk(clk),
      .i_cmd_valid(cmd_valid), .i_cmd_dcx(cmd_dcx), .i_cmd_data(cmd_data),
      .i_cmd_last(cmd_last), .o_cmd_ready(cmd_ready),
      .i_pix_req(pix_req), .i_pix_cont(pix_cont), .i_pix_len(pix_len), .o_pix_gnt(pix_gnt),
      .i_pix_valid(pix_valid), .i_pix_data(pix_data), .o_pix_ready(pix_ready),
      .o_bus_valid(bus_valid), .o_bus_dcx(bus_dcx), .o_bus_data(bus_data),
      .i_bus_ready(bus_ready), .o_grant(grant), .o_busy(busy)
   );

   mpu_bus_arbiter #(.FAIR(1'b0)) dut_unfair (
      .i_arst(arst), .i_sysclk(clk),
      .i_cmd_valid(cmd_valid), .i_cmd_dcx(cmd_dcx), .i_cmd_data(cmd_data),
      .i_cmd_last(cmd_last), .o_cmd_ready(u_cmd_ready),
      .i_pix_req(pix_req), .i_pix_cont(pix_cont), .i_pix_len(pix_len), .o_pix_gnt(u_pix_gnt),
      .i_pix_valid(pix_valid), .i_pix_data(pix_data), .o_pix_ready(u_pix_ready),
      .o_bus_valid(u_bus_valid), .o_bus_dcx(u_bus_dcx), .o_bus_data(u_bus_data),
      .i_bus_ready(bus_ready), .o_grant(u_grant), .o_busy(u_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        cv, cdcx, clast, preq, pcont, pv, rdy;
      logic [15:0] cdata, pdata;
      logic [9:0]  plen;
      logic        bv, bdcx, crdy, prdy, pgnt, bsy;
      logic [15:0] bdata;
      logic [1:0]  gnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic cv, input logic cdcx, input logic [15:0] cdata, input logic clast,
      input logic preq, input logic pcont, input logic [9:0] plen,
      input logic pv, input logic [15:0] pdata, input logic rdy,
      input logic bv, input logic bdcx, input logic [15:0] bdata,
      input logic crdy, input logic prdy, input logic pgnt, input logic [1:0] gnt, input logic bsy);
      vec_t v;
      v.cv = cv; v.cdcx = cdcx; v.cdata = cdata; v.clast = clast;
      v.preq = preq; v.pcont = pcont; v.plen = plen; v.pv = pv; v.pdata = pdata; v.rdy = rdy;
      v.bv = bv; v.bdcx = bdcx; v.bdata = bdata; v.crdy = crdy; v.prdy = prdy;
      v.pgnt = pgnt; v.gnt = gnt; v.bsy = bsy;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cmd_valid = 0; cmd_dcx = 0; cmd_data = '0; cmd_last = 0;
      pix_req = 0; pix_cont = 0; pix_len = '0; pix_valid = 0; pix_data = '0; bus_ready = 1;
   endtask

   task automatic pulse_reset();
      arst = 1'b1;
      #3;
      arst = 1'b0;
      step();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " bus_valid"}, 32'(bus_valid), 0);
      check({tag, " bus_dcx"},   32'(bus_dcx),   0);
      check({tag, " bus_data"},  32'(bus_data),  0);
      check({tag, " cmd_ready"}, 32'(cmd_ready), 0);
      check({tag, " pix_ready"}, 32'(pix_ready), 0);
      check({tag, " pix_gnt"},   32'(pix_gnt),   0);
      check({tag, " grant"},     32'(grant),     0);
      check({tag, " busy"},      32'(busy),      0);
   endtask

   initial begin
      // cmd transaction: 11h then params 0,1
      vecs.push_back(mk(1,0,16'h0011,0, 0,0,0, 0,0,1,     0,0,16'h0000,0,0,0,2'b00,0));
      vecs.push_back(mk(1,0,16'h0011,0, 0,0,0, 0,0,1,     1,0,16'h0011,1,0,0,2'b01,1));
      vecs.push_back(mk(1,1,16'h0000,0, 0,0,0, 0,0,1,     1,1,16'h0000,1,0,0,2'b01,1));
      vecs.push_back(mk(1,1,16'h0001,1, 0,0,0, 0,0,1,     1,1,16'h0001,1,0,0,2'b01,1));
      vecs.push_back(mk(0,0,16'h0000,0, 0,0,0, 0,0,1,     0,0,16'h0000,0,0,0,2'b00,0));
      // pixel burst len 4, RAMWR header; len input changed mid-burst must be ignored
      vecs.push_back(mk(0,0,0,0, 1,0,10'd4, 0,16'h0000,1, 0,0,16'h0000,0,0,0,2'b00,0));
      vecs.push_back(mk(0,0,0,0, 0,0,10'd4, 0,16'h0000,1, 1,0,16'h2C00,0,0,1,2'b10,1));
      vecs.push_back(mk(0,0,0,0, 0,0,10'd7, 1,16'hA001,1, 1,1,16'hA001,0,1,0,2'b10,1));
      vecs.push_back(mk(0,0,0,0, 0,0,10'd7, 1,16'hA002,1, 1,1,16'hA002,0,1,0,2'b10,1));
      vecs.push_back(mk(0,0,0,0, 0,0,10'd7, 1,16'hA003,1, 1,1,16'hA003,0,1,0,2'b10,1));
      vecs.push_back(mk(0,0,0,0, 0,0,10'd7, 1,16'hA004,1, 1,1,16'hA004,0,1,0,2'b10,1));
      vecs.push_back(mk(0,0,0,0, 0,0,10'd7, 0,16'h0000,1, 0,0,16'h0000,0,0,0,2'b00,0));
      // header-only burst, RAMWRC, one stall cycle on the header
      vecs.push_back(mk(0,0,0,0, 1,1,10'd0, 0,16'h0000,1, 0,0,16'h0000,0,0,0,2'b00,0));
      vecs.push_back(mk(0,0,0,0, 0,1,10'd0, 0,16'h0000,0, 1,0,16'h3C00,0,0,1,2'b10,1));
      vecs.push_back(mk(0,0,0,0, 0,1,10'd0, 0,16'h0000,1, 1,0,16'h3C00,0,0,0,2'b10,1));
      vecs.push_back(mk(0,0,0,0, 0,0,10'd0, 0,16'h0000,1, 0,0,16'h0000,0,0,0,2'b00,0));
      // len 3 with ready toggling, valid gaps, and a command waiting behind the burst
      vecs.push_back(mk(0,0,0,0,          1,0,10'd3, 0,16'h0000,1, 0,0,16'h0000,0,0,0,2'b00,0));
      vecs.push_back(mk(0,0,0,0,          0,0,10'd3, 0,16'h0000,0, 1,0,16'h2C00,0,0,1,2'b10,1));
      vecs.push_back(mk(0,0,0,0,          0,0,10'd3, 0,16'h0000,1, 1,0,16'h2C00,0,0,0,2'b10,1));
      vecs.push_back(mk(0,0,0,0,          0,0,10'd3, 1,16'hB001,0, 1,1,16'hB001,0,0,0,2'b10,1));
      vecs.push_back(mk(0,0,0,0,          0,0,10'd3, 1,16'hB001,1, 1,1,16'hB001,0,1,0,2'b10,1));
      vecs.push_back(mk(1,0,16'h0055,1,   0,0,10'd3, 0,16'h0000,0, 0,1,16'h0000,0,0,0,2'b10,1));
      vecs.push_back(mk(1,0,16'h0055,1,   0,0,10'd3, 0,16'h0000,1, 0,1,16'h0000,0,1,0,2'b10,1));
      vecs.push_back(mk(1,0,16'h0055,1,   0,0,10'd3, 1,16'hB002,0, 1,1,16'hB002,0,0,0,2'b10,1));
      vecs.push_back(mk(1,0,16'h0055,1,   0,0,10'd3, 1,16'hB002,1, 1,1,16'hB002,0,1,0,2'b10,1));
      vecs.push_back(mk(1,0,16'h0055,1,   0,0,10'd3, 1,16'hB003,1, 1,1,16'hB003,0,1,0,2'b10,1));
      vecs.push_back(mk(1,0,16'h0055,1,   0,0,10'd0, 0,16'h0000,1, 0,0,16'h0000,0,0,0,2'b00,0));
      vecs.push_back(mk(1,0,16'h0055,1,   0,0,10'd0, 0,16'h0000,1, 1,0,16'h0055,1,0,0,2'b01,1));
      vecs.push_back(mk(0,0,16'h0000,0,   0,0,10'd0, 0,16'h0000,1, 0,0,16'h0000,0,0,0,2'b00,0));

      idle_inputs();
      arst = 1'b1;
      #12;
      check_all_zero("reset");
      check("reset unfair grant", 32'(u_grant), 0);
      @(negedge clk);
      arst = 1'b0;
      step();

      // table
      for (int i = 0; i < vecs.size(); i++) begin
         cmd_valid = vecs[i].cv;   cmd_dcx  = vecs[i].cdcx;  cmd_data = vecs[i].cdata;
         cmd_last  = vecs[i].clast; pix_req = vecs[i].preq;  pix_cont = vecs[i].pcont;
         pix_len   = vecs[i].plen; pix_valid = vecs[i].pv;   pix_data = vecs[i].pdata;
         bus_ready = vecs[i].rdy;
         @(negedge clk);
         check($sformatf("v%0d bus_valid", i), 32'(bus_valid), 32'(vecs[i].bv));
         check($sformatf("v%0d bus_dcx", i),   32'(bus_dcx),   32'(vecs[i].bdcx));
         check($sformatf("v%0d bus_data", i),  32'(bus_data),  32'(vecs[i].bdata));
         check($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].crdy));
         check($sformatf("v%0d pix_ready", i), 32'(pix_ready), 32'(vecs[i].prdy));
         check($sformatf("v%0d pix_gnt", i),   32'(pix_gnt),   32'(vecs[i].pgnt));
         check($sformatf("v%0d grant", i),     32'(grant),     32'(vecs[i].gnt));
         check($sformatf("v%0d busy", i),      32'(busy),      32'(vecs[i].bsy));
         step();
      end

      // contention: single-word commands vs header-only bursts, both always requesting
      begin
         logic [1:0] exp_fair [8];
         logic [1:0] exp_unfair [8];
         exp_fair   = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
         exp_unfair = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
         idle_inputs();
         pulse_reset();
         cmd_valid = 1; cmd_last = 1; cmd_data = 16'h0029;
         pix_req = 1; pix_len = '0;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("fair c%0d grant", c),   32'(grant),   32'(exp_fair[c]));
            check($sformatf("unfair c%0d grant", c), 32'(u_grant), 32'(exp_unfair[c]));
            step();
         end
      end

      // reset in the middle of a len-8 burst after two data beats
      idle_inputs();
      pulse_reset();
      pix_req = 1; pix_len = 10'd8;
      step();
      pix_req = 0;
      step();
      pix_valid = 1; pix_data = 16'hC001;
      step();
      pix_data = 16'hC002;
      step();
      pix_data = 16'hC003;
      #1;
      check("mid-burst bus_valid", 32'(bus_valid), 1);
      arst = 1'b1;
      #1;
      check_all_zero("async reset");
      #1;
      arst = 1'b0;
      pix_valid = 0; pix_data = '0;
      pix_req = 1; pix_len = 10'd1;
      @(negedge clk);
      check("reissue idle grant", 32'(grant), 0);
      step();
      pix_req = 0;
      @(negedge clk);
      check("reissue hdr data", 32'(bus_data), 32'h2C00);
      check("reissue hdr dcx", 32'(bus_dcx), 0);
      check("reissue hdr valid", 32'(bus_valid), 1);
      check("reissue pix_gnt", 32'(pix_gnt), 1);
      step();
      pix_valid = 1; pix_data = 16'hD001;
      @(negedge clk);
      check("reissue data", 32'(bus_data), 32'hD001);
      step();
      pix_valid = 0;
      @(negedge clk);
      check("reissue done busy", 32'(busy), 0);
      step();

      // maximum burst length: 1023 beats, counter must not wrap
      pix_req = 1; pix_len = 10'h3FF; pix_cont = 0;
      step();
      pix_req = 0;
      @(negedge clk);
      check("maxlen hdr data", 32'(bus_data), 32'h2C00);
      step();
      pix_valid = 1;
      for (int b = 0; b < 1023; b++) begin
         pix_data = 16'(b);
         if (b == 1022) begin
            @(negedge clk);
            check("maxlen last busy", 32'(busy), 1);
            check("maxlen last grant", 32'(grant), 32'h2);
            check("maxlen last data", 32'(bus_data), 32'd1022);
         end
         step();
      end
      pix_valid = 0;
      @(negedge clk);
      check("maxlen end busy", 32'(busy), 0);
      check("maxlen end pix_ready", 32'(pix_ready), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
